// File: rtl/arb_pkg.sv
// Purpose : shared defaults and the routing helper for the 2x2 flit router.
// Latency : n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: DEF_* parameter defaults, VALID_BIT, route_is_out1().
package arb_pkg;

    localparam int         DEF_FLIT_W    = 10;
    localparam int         DEF_DEST_LSB  = 6;
    localparam int         DEF_DEST_W    = 3;
    localparam logic [2:0] DEF_OUT1_DEST = 3'b010;
    localparam int         VALID_BIT     = DEF_FLIT_W - 1;

    // Route bit for a flit: 1 when its destination field equals out1_dest.
    // Arguments are widened to 64 bits so the same helper serves any
    // parameterisation of the router.
    function automatic logic route_is_out1(
        input logic [63:0] flit,
        input int          dest_lsb,
        input int          dest_w,
        input logic [63:0] out1_dest
    );
        logic [63:0] mask;
        mask = (64'd1 << dest_w) - 64'd1;
        return ((flit >> dest_lsb) & mask) == (out1_dest & mask);
    endfunction

endpackage

// File: rtl/arb_hold_slot.sv
// Purpose : one-entry input holding slot storing a flit and its precomputed route bit.
// Latency : flit captured at the accepting edge, visible on flit_o the cycle after.
// Backpressure: rdy_o = empty OR granted this cycle, so a drained slot refills in the same cycle.
// Ports   : clk, rst_n (sync, active low); flit_i (MSB = valid) in; grant_i drains the slot;
//           rdy_o accept; full_o / flit_o / route_o expose the held flit (route 1 = out1).
module arb_hold_slot
    import arb_pkg::*;
#(
    parameter int                FLIT_W    = DEF_FLIT_W,
    parameter int                DEST_LSB  = DEF_DEST_LSB,
    parameter int                DEST_W    = DEF_DEST_W,
    parameter logic [DEST_W-1:0] OUT1_DEST = DEST_W'(DEF_OUT1_DEST)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] flit_i,
    input  logic              grant_i,
    output logic              rdy_o,
    output logic              full_o,
    output logic [FLIT_W-1:0] flit_o,
    output logic              route_o
);

    logic              full_q;
    logic [FLIT_W-1:0] flit_q;
    logic              route_q;
    logic              capture;

    assign rdy_o   = !full_q || grant_i;
    // Flits without the valid bit never occupy the slot.
    assign capture = flit_i[FLIT_W-1] && rdy_o;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q  <= 1'b0;
            flit_q  <= '0;
            route_q <= 1'b0;
        end else if (capture) begin
            full_q  <= 1'b1;
            flit_q  <= flit_i;
            route_q <= route_is_out1(64'(flit_i), DEST_LSB, DEST_W, 64'(OUT1_DEST));
        end else if (grant_i) begin
            full_q  <= 1'b0;
        end
    end

    assign full_o  = full_q;
    assign flit_o  = flit_q;
    assign route_o = route_q;

endmodule

// File: rtl/arb_router2.sv
// Purpose : registered 2-in/2-out flit router with round-robin arbitration on output conflicts.
// Latency : 2 cycles minimum from input handshake to output valid (slot, then output register).
// Backpressure: outX holds while valid && !outX_rdy; blocked slots drop inpX_rdy combinationally.
// Ports   : clk, rst_n (sync, active low); inp1/inp2 flits (MSB = valid) with inp1_rdy/inp2_rdy;
//           out1 (OUT1_DEST traffic) / out2 (everything else) with out1_rdy/out2_rdy.
// Option  : define ARB_ROUTER_STATS_EN to add conflict_cnt[15:0], a saturating conflict counter.
module arb_router2
    import arb_pkg::*;
#(
    parameter int                FLIT_W    = DEF_FLIT_W,
    parameter int                DEST_LSB  = DEF_DEST_LSB,
    parameter int                DEST_W    = DEF_DEST_W,
    parameter logic [DEST_W-1:0] OUT1_DEST = DEST_W'(DEF_OUT1_DEST),
    parameter bit                PRI_INIT  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] inp1,
    output logic              inp1_rdy,
    input  logic [FLIT_W-1:0] inp2,
    output logic              inp2_rdy,
    output logic [FLIT_W-1:0] out1,
    input  logic              out1_rdy,
    output logic [FLIT_W-1:0] out2,
    input  logic              out2_rdy
`ifdef ARB_ROUTER_STATS_EN
    ,
    output logic [15:0]       conflict_cnt
`endif
);

    localparam int VB = FLIT_W - 1;

    // Index 0 is input 1, index 1 is input 2.
    logic [1:0]        s_full;
    logic [1:0]        s_route;
    logic [1:0]        grant;
    logic [1:0]        req1;
    logic [1:0]        req2;
    logic [FLIT_W-1:0] s_flit [2];

    logic [FLIT_W-1:0] out1_q, out1_d;
    logic [FLIT_W-1:0] out2_q, out2_d;
    logic              rr_q, rr_d;
    logic              conflict;

    arb_hold_slot #(
        .FLIT_W   (FLIT_W),
        .DEST_LSB (DEST_LSB),
        .DEST_W   (DEST_W),
        .OUT1_DEST(OUT1_DEST)
    ) u_slot1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .flit_i (inp1),
        .grant_i(grant[0]),
        .rdy_o  (inp1_rdy),
        .full_o (s_full[0]),
        .flit_o (s_flit[0]),
        .route_o(s_route[0])
    );

    arb_hold_slot #(
        .FLIT_W   (FLIT_W),
        .DEST_LSB (DEST_LSB),
        .DEST_W   (DEST_W),
        .OUT1_DEST(OUT1_DEST)
    ) u_slot2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .flit_i (inp2),
        .grant_i(grant[1]),
        .rdy_o  (inp2_rdy),
        .full_o (s_full[1]),
        .flit_o (s_flit[1]),
        .route_o(s_route[1])
    );

    always_comb begin
        grant    = '0;
        out1_d   = out1_q;
        out2_d   = out2_q;
        conflict = 1'b0;
        req1     = s_full & s_route;
        req2     = s_full & ~s_route;

        // Output loadable: empty or being consumed this cycle. A consumed
        // output with no new grant only loses its valid bit.
        if (!out1_q[VB] || out1_rdy) begin
            out1_d[VB] = 1'b0;
            if (req1 == 2'b11) begin
                conflict    = 1'b1;
                grant[rr_q] = 1'b1;
                out1_d      = s_flit[rr_q];
            end else if (req1[0]) begin
                grant[0] = 1'b1;
                out1_d   = s_flit[0];
            end else if (req1[1]) begin
                grant[1] = 1'b1;
                out1_d   = s_flit[1];
            end
        end

        if (!out2_q[VB] || out2_rdy) begin
            out2_d[VB] = 1'b0;
            if (req2 == 2'b11) begin
                conflict    = 1'b1;
                grant[rr_q] = 1'b1;
                out2_d      = s_flit[rr_q];
            end else if (req2[0]) begin
                grant[0] = 1'b1;
                out2_d   = s_flit[0];
            end else if (req2[1]) begin
                grant[1] = 1'b1;
                out2_d   = s_flit[1];
            end
        end

        // Both slots can contend for only one output at a time, so at most
        // one conflict grant happens per cycle and the pointer flips once.
        rr_d = rr_q ^ conflict;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out1_q <= '0;
            out2_q <= '0;
            rr_q   <= PRI_INIT;
        end else begin
            out1_q <= out1_d;
            out2_q <= out2_d;
            rr_q   <= rr_d;
        end
    end

    assign out1 = out1_q;
    assign out2 = out2_q;

`ifdef ARB_ROUTER_STATS_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (conflict && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign conflict_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_arb_router2.sv
// Purpose : self-checking bench for arb_router2 (directed scenarios plus randomized traffic).
// Latency : n/a.
// Backpressure: exercised by randomized and directed outX_rdy patterns.
module tb_arb_router2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] inp1, inp2, out1, out2;
    logic       inp1_rdy, inp2_rdy, out1_rdy, out2_rdy;
`ifdef ARB_ROUTER_STATS_EN
    logic [15:0] conflict_cnt;
`endif

    always #5 clk = ~clk;

    arb_router2 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .inp1    (inp1),
        .inp1_rdy(inp1_rdy),
        .inp2    (inp2),
        .inp2_rdy(inp2_rdy),
        .out1    (out1),
        .out1_rdy(out1_rdy),
        .out2    (out2),
        .out2_rdy(out2_rdy)
`ifdef ARB_ROUTER_STATS_EN
        ,
        .conflict_cnt(conflict_cnt)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected-flit queues: q<output><input>, filled at acceptance.
    logic [9:0] q1a[$], q1b[$], q2a[$], q2b[$];
    logic [9:0] log1[$];
    bit         acc1, acc2;
    bit         h1, h2;
    logic [9:0] hv1, hv2;
    logic [4:0] seq1 = '0, seq2 = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit goes_out1(input logic [9:0] f);
        return f[8:6] == 3'b010;
    endfunction

    // A delivered flit must be the oldest outstanding flit of one of the inputs.
    task automatic sb_match(input int o, input logic [9:0] f);
        bit         ok = 1'b0;
        logic [9:0] ha = 'x, hb = 'x;
        if (o == 1) begin
            if (q1a.size() > 0) ha = q1a[0];
            if (q1b.size() > 0) hb = q1b[0];
            if (q1a.size() > 0 && q1a[0] == f) begin void'(q1a.pop_front()); ok = 1'b1; end
            else if (q1b.size() > 0 && q1b[0] == f) begin void'(q1b.pop_front()); ok = 1'b1; end
        end else begin
            if (q2a.size() > 0) ha = q2a[0];
            if (q2b.size() > 0) hb = q2b[0];
            if (q2a.size() > 0 && q2a[0] == f) begin void'(q2a.pop_front()); ok = 1'b1; end
            else if (q2b.size() > 0 && q2b[0] == f) begin void'(q2b.pop_front()); ok = 1'b1; end
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL out%0d_order: got %h expected head %h or %h", o, f, ha, hb);
        end
    endtask

    // Monitor: acceptance pushes, output handshakes pop and compare.
    always @(negedge clk) begin
        acc1 = 1'b0;
        acc2 = 1'b0;
        if (!rst_n) begin
            q1a.delete(); q1b.delete(); q2a.delete(); q2b.delete();
            h1 = 1'b0;
            h2 = 1'b0;
        end else begin
            if (inp1[9] && inp1_rdy) begin
                acc1 = 1'b1;
                if (goes_out1(inp1)) q1a.push_back(inp1); else q2a.push_back(inp1);
            end
            if (inp2[9] && inp2_rdy) begin
                acc2 = 1'b1;
                if (goes_out1(inp2)) q1b.push_back(inp2); else q2b.push_back(inp2);
            end
            if (h1) chk("out1_stable", out1, hv1);
            if (h2) chk("out2_stable", out2, hv2);
            h1  = out1[9] && !out1_rdy;
            hv1 = out1;
            h2  = out2[9] && !out2_rdy;
            hv2 = out2;
            if (out1[9] && out1_rdy) begin
                log1.push_back(out1);
                sb_match(1, out1);
            end
            if (out2[9] && out2_rdy) sb_match(2, out2);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic new_flit(input bit src2, input int pd, output logic [9:0] f);
        logic [2:0] d;
        if ($urandom_range(99) < pd) d = 3'b010;
        else begin
            d = 3'($urandom_range(7));
            if (d == 3'b010) d = 3'b101;
        end
        if (src2) begin f = {1'b1, d, 1'b1, seq2}; seq2++; end
        else      begin f = {1'b1, d, 1'b0, seq1}; seq1++; end
    endtask

    // pv: % valid, pd: % routed to out1, pr: % downstream ready.
    task automatic rnd_drive(input int ncyc, input int pv, input int pd, input int pr);
        logic [9:0] f;
        for (int c = 0; c < ncyc; c++) begin
            if (!inp1[9] || acc1) begin
                new_flit(1'b0, pd, f);
                inp1 = ($urandom_range(99) < pv) ? f : 10'h000;
            end
            if (!inp2[9] || acc2) begin
                new_flit(1'b1, pd, f);
                inp2 = ($urandom_range(99) < pv) ? f : 10'h000;
            end
            out1_rdy = ($urandom_range(99) < pr);
            out2_rdy = ($urandom_range(99) < pr);
            cyc();
        end
    endtask

    task automatic chk_log(input string nm, input logic [9:0] e0, input logic [9:0] e1,
                           input logic [9:0] e2, input logic [9:0] e3, input int n);
        logic [9:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        chk({nm, "_count"}, log1.size(), n);
        for (int i = 0; i < n && i < log1.size(); i++) chk({nm, "_seq"}, log1[i], e[i]);
    endtask

    initial begin
        rst_n = 1'b0;
        inp1 = '0; inp2 = '0;
        out1_rdy = 1'b1; out2_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out1", out1, 10'h000);
        chk("rst_out2", out2, 10'h000);
        chk("rst_inp1_rdy", inp1_rdy, 1);
        chk("rst_inp2_rdy", inp2_rdy, 1);
`ifdef ARB_ROUTER_STATS_EN
        chk("rst_cnt", conflict_cnt, 0);
`endif
        cyc();

        // Single route with 2-cycle latency.
        inp1 = 10'h285; cyc(); inp1 = '0;
        @(negedge clk); chk("t1_early", out1[9], 0);
        cyc();
        @(negedge clk); chk("t1_out1", out1, 10'h285); chk("t1_out2v", out2[9], 0);
        cyc();
        @(negedge clk); chk("t1_drain", out1[9], 0);
        cyc();

        // Parallel, different outputs.
        inp1 = 10'h285; inp2 = 10'h243; cyc(); inp1 = '0; inp2 = '0;
        cyc();
        @(negedge clk); chk("t2_out1", out1, 10'h285); chk("t2_out2", out2, 10'h243);
        cyc(); idle(2);

        // Conflict round robin, pointer starts at input 1.
        log1.delete();
        inp1 = 10'h285; inp2 = 10'h28A; cyc(); inp1 = '0; inp2 = '0;
        @(negedge clk); chk("t3_inp2_wait", inp2_rdy, 0); chk("t3_inp1_rdy", inp1_rdy, 1);
        idle(4);
        inp1 = 10'h285; inp2 = 10'h28A; cyc(); inp1 = '0; inp2 = '0;
        @(negedge clk); chk("t3_inp1_wait", inp1_rdy, 0); chk("t3_inp2_rdy", inp2_rdy, 1);
        idle(4);
        chk_log("t3_rr", 10'h285, 10'h28A, 10'h28A, 10'h285, 4);
`ifdef ARB_ROUTER_STATS_EN
        chk("t3_cnt", conflict_cnt, 2);
`endif

        // Backpressure on out1.
        log1.delete();
        out1_rdy = 1'b0;
        inp1 = 10'h285; cyc(); inp1 = 10'h286; cyc(); inp1 = 10'h287;
        @(negedge clk); chk("t4_hold", out1, 10'h285); chk("t4_inp1_blk", inp1_rdy, 0);
        repeat (3) begin cyc(); @(negedge clk); chk("t4_hold", out1, 10'h285); end
        cyc(); out1_rdy = 1'b1;
        @(negedge clk); chk("t4_release_rdy", inp1_rdy, 1);
        cyc(); inp1 = '0;
        idle(4);
        chk_log("t4_bp", 10'h285, 10'h286, 10'h287, 10'h000, 3);

        // Reset mid-operation; leave the pointer at input 2 first.
        inp1 = 10'h285; inp2 = 10'h28A; cyc(); inp1 = '0; inp2 = '0;
        idle(4);
`ifdef ARB_ROUTER_STATS_EN
        chk("t5_cnt3", conflict_cnt, 3);
`endif
        out1_rdy = 1'b0; out2_rdy = 1'b0;
        inp1 = 10'h285; inp2 = 10'h243;
        idle(3);
        inp1 = '0; inp2 = '0;
        @(negedge clk); chk("t5_full1", out1[9], 1); chk("t5_full2", out2[9], 1);
        chk("t5_slot_full", inp1_rdy, 0);
        cyc(); rst_n = 1'b0; cyc(); rst_n = 1'b1;
        out1_rdy = 1'b1; out2_rdy = 1'b1;
        @(negedge clk);
        chk("t5_out1", out1, 10'h000); chk("t5_out2", out2, 10'h000);
        chk("t5_inp1_rdy", inp1_rdy, 1); chk("t5_inp2_rdy", inp2_rdy, 1);
`ifdef ARB_ROUTER_STATS_EN
        chk("t5_cnt_rst", conflict_cnt, 0);
`endif
        log1.delete();
        cyc();
        inp1 = 10'h285; inp2 = 10'h28A; cyc(); inp1 = '0; inp2 = '0;
        idle(4);
        chk_log("t5_rr_init", 10'h285, 10'h28A, 10'h000, 10'h000, 2);
`ifdef ARB_ROUTER_STATS_EN
        chk("t5_cnt1", conflict_cnt, 1);
`endif

        // Randomized traffic against the scoreboard.
        rnd_drive(3000, 70, 50, 70);
        inp1 = '0; inp2 = '0; out1_rdy = 1'b1; out2_rdy = 1'b1;
        idle(20);
        chk("rnd_pending", q1a.size() + q1b.size() + q2a.size() + q2b.size(), 0);

`ifdef ARB_ROUTER_STATS_EN
        // Continuous contention for out1: one conflict every cycle.
        rnd_drive(65540, 100, 100, 100);
        inp1 = '0; inp2 = '0; out1_rdy = 1'b1; out2_rdy = 1'b1;
        idle(10);
        chk("sat_cnt", conflict_cnt, 16'hFFFF);
        chk("sat_pending", q1a.size() + q1b.size() + q2a.size() + q2b.size(), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_router2.md
Name: arb_router2

Overview:
- Registered 2-input, 2-output flit router/arbiter.
- Flit format: MSB is the valid bit; field [DEST_LSB+DEST_W-1:DEST_LSB] is the destination code.
- A flit whose destination code equals OUT1_DEST goes to out1; any other code goes to out2.
- Adds per-input holding slots, valid/ready backpressure, registered outputs and round-robin arbitration on output conflicts.
- Sits between the flit sources and the downstream link stages.

Parameters:
- FLIT_W, 10, total flit width; bit FLIT_W-1 is the valid bit.
- DEST_LSB, 6, LSB of the destination field.
- DEST_W, 3, width of the destination field.
- OUT1_DEST, 3'b010, destination code routed to out1.
- PRI_INIT, 0, round-robin pointer value at reset (0 = inp1 favoured, 1 = inp2 favoured).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- inp1  in  FLIT_W  input flit, channel 1; MSB = valid.
- inp1_rdy  out  1  channel 1 accept; a transfer occurs when inp1[MSB] & inp1_rdy.
- inp2  in  FLIT_W  input flit, channel 2.
- inp2_rdy  out  1  channel 2 accept.
- out1  out  FLIT_W  registered output flit for OUT1_DEST traffic; MSB = valid.
- out1_rdy  in  1  downstream accept for out1.
- out2  out  FLIT_W  registered output flit for all other destinations.
- out2_rdy  in  1  downstream accept for out2.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out1 = 0 and out2 = 0, so both valid bits are 0.
  - Both hold slots are empty.
  - rr_ptr = PRI_INIT.
  - inpX_rdy = 1 from the first cycle after reset.
  - Reset mid-transfer discards every held and output flit; no partial state survives.
- Hold slot per input: a one-entry buffer storing the flit and a precomputed route bit (1 = out1).
  - inpX_rdy = slot empty OR slot granted this cycle. This is combinational and gives 1 flit/cycle/input throughput.
  - Input flits with MSB=0 are never captured.
- Output register X is loadable when outX[MSB]=0 OR outX_rdy=1.
  - While outX[MSB]=1 and outX_rdy=0, outX holds stable (no change to any bit).
  - When outX is consumed and nothing is granted to it, outX[MSB] is cleared to 0 at the edge.
- Arbitration, per output, each cycle:
  - Requesters are the full slots whose route bit matches that output.
  - One requester, and output loadable: grant that slot.
  - Two requesters: grant the slot selected by rr_ptr. At the edge, rr_ptr flips to the other input. The loser stays in its slot and its rdy stays 0.
  - rr_ptr changes only on a conflict grant.
  - Both inputs targeting different outputs: both are granted the same cycle. No interaction between them, and rr_ptr is unchanged.
- Latency:
  - Flit accepted at edge N sits in its slot after N.
  - If granted, it appears on outX after edge N+1 (2-cycle minimum, input handshake to output valid).
- Ordering: flits from one input are delivered in acceptance order. There is no ordering guarantee between inputs.
- Width rule: the flit is passed through unchanged, with no field rewriting.

Optional Feature:
- Macro ARB_ROUTER_STATS_EN.
- Defined: adds output port conflict_cnt [15:0].
  - Increments by 1 on every cycle with a conflict grant (two requesters, one output).
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined: the port and counter logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package arb_pkg holds:
  - default FLIT_W, DEST_LSB, DEST_W, OUT1_DEST;
  - the localparam VALID_BIT;
  - function route_is_out1(flit) returning the route bit.
- Sub-module arb_hold_slot (one-entry buffer with valid, rdy, grant-drain and route bit), instantiated twice.
- Arbitration, rr_ptr and output registers stay in the top module.

Test Plan:
- Single route: inp1=10'h285 for 1 cycle, out1_rdy=1 → out1=10'h285 two edges after acceptance, then out1[9]=0; out2 stays 0.
- Parallel, no conflict: inp1=10'h285, inp2=10'h243 in the same cycle → out1=10'h285 and out2=10'h243 in the same cycle; rr_ptr unchanged.
- Conflict round-robin: PRI_INIT=0; inp1=10'h285 and inp2=10'h28A together, repeated twice → out1 sequence is 285, 28A, then 28A, 285 (pointer alternates); inp2_rdy=0 while its flit waits.
- Backpressure: out1_rdy=0, inp1 streams 10'h285 then 10'h286 → out1 holds 285 stable, the slot fills, inp1_rdy=0; release out1_rdy → 286 follows with no loss or duplication.
- Reset mid-operation: hold slots and outputs full, rst_n=0 for 1 cycle → out1=out2=0, inp1_rdy=inp2_rdy=1 next cycle, rr_ptr=PRI_INIT.
- Stats (ARB_ROUTER_STATS_EN): 3 conflict cycles → conflict_cnt=3; force 65540 conflicts → conflict_cnt holds at 16'hFFFF.
